// File: rtl/alu_operand_sequencer.sv
// Byte-stream front end for the 8-bit combinational ALU: collects opcode/A/B, drives the ALU from
// registers, waits EXEC_CYCLES for it to settle, and returns the result over valid/ready.
module alu_operand_sequencer #(
  parameter int EXEC_CYCLES = 1,
  parameter bit CHAIN_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] alu_instr,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_result,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_err,
  output logic       busy
);

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  typedef enum logic [2:0] {
    LOAD_OP = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    EXEC    = 3'd3,
    RESULT  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [2:0]  r_op;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [7:0]  r_acc;
  logic        r_acc_valid;
  logic [3:0]  r_cnt;
  logic [7:0]  r_out_data;
  logic        r_out_err;
  logic        r_out_valid;

  logic        w_in_xfer;
  logic        w_out_xfer;
  logic        w_chain;
  logic        w_capture;
  logic        w_op_illegal;
  logic        w_unused_hi;

  // Opcode bits 7:4 carry no meaning for this ALU.
  assign w_unused_hi  = ^in_data[7:4];

  assign in_ready     = (r_state == LOAD_OP) || (r_state == LOAD_A) || (r_state == LOAD_B);
  assign busy         = (r_state != LOAD_OP);
  assign w_in_xfer    = in_valid & in_ready;
  assign w_out_xfer   = r_out_valid & out_ready;
  assign w_chain      = CHAIN_EN & in_data[3] & r_acc_valid;
  assign w_capture    = (r_state == EXEC) && (r_cnt == 4'd0);
  assign w_op_illegal = r_op[2] & r_op[1];

  assign alu_instr    = {5'b00000, r_op};
  assign alu_a        = r_a;
  assign alu_b        = r_b;
  assign out_data     = r_out_data;
  assign out_err      = r_out_err;
  assign out_valid    = r_out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LOAD_OP;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LOAD_OP: begin
        if (w_in_xfer) begin
          w_state_nxt = w_chain ? LOAD_B : LOAD_A;
        end
      end
      LOAD_A: begin
        if (w_in_xfer) begin
          w_state_nxt = LOAD_B;
        end
      end
      LOAD_B: begin
        if (w_in_xfer) begin
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = RESULT;
        end
      end
      RESULT: begin
        if (w_out_xfer) begin
          w_state_nxt = LOAD_OP;
        end
      end
      default: w_state_nxt = LOAD_OP;
    endcase
  end

  // Operand capture: a chained op takes A from the last legal result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op <= 3'd0;
      r_a  <= 8'd0;
      r_b  <= 8'd0;
    end else begin
      if ((r_state == LOAD_OP) && w_in_xfer) begin
        r_op <= in_data[2:0];
        if (w_chain) begin
          r_a <= r_acc;
        end
      end
      if ((r_state == LOAD_A) && w_in_xfer) begin
        r_a <= in_data;
      end
      if ((r_state == LOAD_B) && w_in_xfer) begin
        r_b <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if ((r_state == LOAD_B) && w_in_xfer) begin
      r_cnt <= CNT_INIT;
    end else if ((r_state == EXEC) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Illegal opcodes still report a result but never become the chain source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= 8'd0;
      r_acc_valid <= 1'b0;
    end else if (w_capture && !w_op_illegal) begin
      r_acc       <= alu_result;
      r_acc_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= 8'd0;
      r_out_err   <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_capture) begin
      r_out_data  <= alu_result;
      r_out_err   <= w_op_illegal;
      r_out_valid <= 1'b1;
    end else if (w_out_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer: a behavioural ALU closes the loop, a vector table
// covers the op map and chaining, and hand sequences cover backpressure and mid-op reset.
module tb_alu_operand_sequencer;

  localparam int EXEC = 3;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] alu_instr;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_result;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  alu_operand_sequencer #(.EXEC_CYCLES(EXEC), .CHAIN_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_instr (alu_instr),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_result(alu_result),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_err   (out_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    alu_result = 8'h00;
    case (alu_instr[2:0])
      3'b000: alu_result = alu_a | alu_b;
      3'b001: alu_result = ~(alu_a & alu_b);
      3'b010: alu_result = ~(alu_a | alu_b);
      3'b011: alu_result = alu_a & alu_b;
      3'b100: alu_result = alu_a + alu_b;
      3'b101: alu_result = alu_b - alu_a;
      default: alu_result = 8'h00;
    endcase
  end

  typedef struct {
    logic [7:0] op;
    logic [7:0] a;
    logic [7:0] b;
    bit         chain;
    logic [7:0] exp_data;
    bit         exp_err;
    logic [7:0] exp_a;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 32'(in_ready), 32'd1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    send_byte(v.op);
    if (!v.chain) send_byte(v.a);
    send_byte(v.b);
    chk($sformatf("v%0d_exec_busy", idx), 32'(busy), 32'd1);
    chk($sformatf("v%0d_exec_in_ready", idx), 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk($sformatf("v%0d_latency", idx), 32'(n), 32'(EXEC));
    chk($sformatf("v%0d_data", idx), 32'(out_data), 32'(v.exp_data));
    chk($sformatf("v%0d_err", idx), 32'(out_err), 32'(v.exp_err));
    chk($sformatf("v%0d_alu_a", idx), 32'(alu_a), 32'(v.exp_a));
    chk($sformatf("v%0d_alu_b", idx), 32'(alu_b), 32'(v.b));
    chk($sformatf("v%0d_alu_instr", idx), 32'(alu_instr), {29'd0, v.op[2:0]});
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk($sformatf("v%0d_post_valid", idx), 32'(out_valid), 32'd0);
    chk($sformatf("v%0d_post_in_ready", idx), 32'(in_ready), 32'd1);
    chk($sformatf("v%0d_post_busy", idx), 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t rv;
    int   n;

    //                  op     a      b      chain data   err   alu_a
    vecs[0]  = '{8'h04, 8'h0F, 8'hF5, 1'b0, 8'h04, 1'b0, 8'h0F};
    vecs[1]  = '{8'h0C, 8'h00, 8'h10, 1'b1, 8'h14, 1'b0, 8'h04};
    vecs[2]  = '{8'h06, 8'hAA, 8'h55, 1'b0, 8'h00, 1'b1, 8'hAA};
    vecs[3]  = '{8'h0C, 8'h00, 8'h01, 1'b1, 8'h15, 1'b0, 8'h14};
    vecs[4]  = '{8'h05, 8'h03, 8'h01, 1'b0, 8'hFE, 1'b0, 8'h03};
    vecs[5]  = '{8'h01, 8'hF0, 8'h3C, 1'b0, 8'hCF, 1'b0, 8'hF0};
    vecs[6]  = '{8'h00, 8'h12, 8'h21, 1'b0, 8'h33, 1'b0, 8'h12};
    vecs[7]  = '{8'h02, 8'h0F, 8'hF0, 1'b0, 8'h00, 1'b0, 8'h0F};
    vecs[8]  = '{8'h03, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, 8'hF0};
    vecs[9]  = '{8'hF4, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 8'h01};
    vecs[10] = '{8'h05, 8'h10, 8'h05, 1'b0, 8'hF5, 1'b0, 8'h10};
    vecs[11] = '{8'h0D, 8'h00, 8'h20, 1'b1, 8'h2B, 1'b0, 8'hF5};

    rst_n     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_alu", {8'd0, alu_instr, alu_a, alu_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], i);
    end

    // Result held under backpressure; input stream ignored meanwhile.
    send_byte(8'h03);
    send_byte(8'hFF);
    send_byte(8'h81);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_latency", 32'(n), 32'(EXEC));
    in_data  = 8'h5A;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d_data", c), 32'(out_data), 32'h81);
      chk($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_post_valid", 32'(out_valid), 32'd0);
    chk("bp_post_in_ready", 32'(in_ready), 32'd1);
    chk("bp_post_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_no_extra_accept", 32'(busy), 32'd0);

    // Reset while waiting for B: partial op dropped and chain source invalidated.
    send_byte(8'h00);
    send_byte(8'h11);
    chk("mid_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rv = '{8'h0C, 8'h22, 8'h11, 1'b0, 8'h33, 1'b0, 8'h22};
    run_vec(rv, 99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d checks expected completion", checks);
    $fatal(1, "timeout");
  end

endmodule
